// File: rtl/mem_tx_reader.sv
// mem_tx_reader: streams a block of message-RAM words
// toward the MKIO transmit serializer over valid/ready.
module mem_tx_reader #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [4:0]            word_count,
  input  logic                  abort,
  output logic [ADDR_WIDTH-1:0] read_addr,
  input  logic [DATA_WIDTH-1:0] q,
  output logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic                  tx_last,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    LOAD,
    SEND
  } state_t;

  state_t                state_q;
  state_t                state_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH-1:0] addr_d;
  logic [5:0]            rem_q;
  logic [5:0]            rem_d;
  logic [DATA_WIDTH-1:0] data_q;
  logic [DATA_WIDTH-1:0] data_d;
  logic                  valid_q;
  logic                  valid_d;
  logic                  last_q;
  logic                  last_d;
  logic                  busy_q;
  logic                  busy_d;
  logic                  done_q;
  logic                  done_d;
  logic                  accept;
  logic                  kill;
  logic                  is_last;
  logic [5:0]            rem_init;

  assign accept   = valid_q & tx_ready;
  assign kill     = abort & (state_q != IDLE);
  assign is_last  = (rem_q == 6'd1);
  assign rem_init = (word_count == 5'd0)
                  ? 6'd32
                  : {1'b0, word_count};

  // next state and next register values
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    data_d  = data_q;
    valid_d = valid_q;
    last_d  = last_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    if (kill) begin
      state_d = IDLE;
      valid_d = 1'b0;
      last_d  = 1'b0;
      busy_d  = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start && !abort) begin
            addr_d  = base_addr;
            rem_d   = rem_init;
            busy_d  = 1'b1;
            state_d = ADDR;
          end
        end
        ADDR: begin
          state_d = LOAD;
        end
        LOAD: begin
          data_d  = q;
          valid_d = 1'b1;
          last_d  = is_last;
          state_d = SEND;
        end
        SEND: begin
          if (accept) begin
            valid_d = 1'b0;
            unique case (1'b1)
              is_last: begin
                last_d  = 1'b0;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = IDLE;
              end
              !is_last: begin
                rem_d   = rem_q - 6'd1;
                addr_d  = addr_q + ADDR_WIDTH'(1);
                state_d = ADDR;
              end
            endcase
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // state and datapath registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign read_addr = addr_q;
  assign tx_data   = data_q;
  assign tx_valid  = valid_q;
  assign tx_last   = last_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_mem_tx_reader.sv
// tb_mem_tx_reader: directed bench for mem_tx_reader
// with a registered-read message RAM model.
module tb_mem_tx_reader;

  localparam int DW = 16;
  localparam int AW = 5;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          tx_ready = 1'b1;
  logic [AW-1:0] base_addr = '0;
  logic [4:0]    word_count = '0;
  logic [AW-1:0] read_addr;
  logic [DW-1:0] q = '0;
  logic [DW-1:0] tx_data;
  logic          tx_valid;
  logic          tx_last;
  logic          busy;
  logic          done;

  logic [DW-1:0] ram [32];

  int total = 0;
  int bad = 0;
  int cyc = 0;

  logic [DW-1:0] got_d[$];
  logic          got_l[$];
  int            acc_cyc[$];
  int            rise_cyc[$];
  int            done_cnt;
  int            done_cyc;
  int            busy_at_done;
  int            unstable;
  int            stalls;
  int            start_cyc;

  mem_tx_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .start      (start),
    .base_addr  (base_addr),
    .word_count (word_count),
    .abort      (abort),
    .read_addr  (read_addr),
    .q          (q),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .tx_last    (tx_last),
    .busy       (busy),
    .done       (done)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // message RAM read port: one-cycle registered read
  always @(posedge clock) q <= ram[read_addr];

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic start_block(input logic [4:0] b, input logic [4:0] n);
    start = 1'b1;
    base_addr = b;
    word_count = n;
    tick();
    start = 1'b0;
    start_cyc = cyc;
  endtask

  // record accepted words, valid rises, done pulses and hold stability
  task automatic collect(input int ncyc, input int stall_word,
                         input int stall_len, input bit pulse);
    int acc;
    int left;
    logic prev_v;
    logic holding;
    logic [DW-1:0] hold_d;
    logic hold_l;
    acc = 0;
    left = stall_len;
    prev_v = tx_valid;
    holding = 1'b0;
    hold_d = '0;
    hold_l = 1'b0;
    got_d.delete();
    got_l.delete();
    acc_cyc.delete();
    rise_cyc.delete();
    done_cnt = 0;
    done_cyc = -1;
    busy_at_done = -1;
    unstable = 0;
    stalls = 0;
    for (int i = 0; i < ncyc; i++) begin
      if (tx_valid && !prev_v) rise_cyc.push_back(cyc);
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        busy_at_done = int'(busy);
      end
      if (holding) begin
        if (!tx_valid || tx_data !== hold_d || tx_last !== hold_l)
          unstable++;
      end
      holding = 1'b0;
      if (tx_valid && acc == stall_word && left > 0) begin
        tx_ready = 1'b0;
        left--;
        stalls++;
        holding = 1'b1;
        hold_d = tx_data;
        hold_l = tx_last;
      end else begin
        tx_ready = 1'b1;
      end
      if (pulse && (i % 2 == 1) && i < 8) begin
        start = 1'b1;
        base_addr = 5'd20;
        word_count = 5'd1;
      end else begin
        start = 1'b0;
      end
      if (tx_valid && tx_ready) begin
        got_d.push_back(tx_data);
        got_l.push_back(tx_last);
        acc_cyc.push_back(cyc + 1);
        acc++;
      end
      prev_v = tx_valid;
      tick();
    end
    start = 1'b0;
    tx_ready = 1'b1;
  endtask

  task automatic test_reset;
    tick();
    tick();
    total++;
    if (read_addr !== 5'd0) begin
      bad++;
      $display("FAIL reset_read_addr: got %h want 00", read_addr);
    end
    total++;
    if (tx_data !== 16'h0000) begin
      bad++;
      $display("FAIL reset_tx_data: got %h want 0000", tx_data);
    end
    total++;
    if (tx_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_tx_valid: got %b want 0", tx_valid);
    end
    total++;
    if (tx_last !== 1'b0) begin
      bad++;
      $display("FAIL reset_tx_last: got %b want 0", tx_last);
    end
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_busy: got %b want 0", busy);
    end
    total++;
    if (done !== 1'b0) begin
      bad++;
      $display("FAIL reset_done: got %b want 0", done);
    end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_basic;
    logic [DW-1:0] g;
    logic gl;
    start_block(5'd4, 5'd3);
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL basic_busy_start: got %b want 1", busy);
    end
    total++;
    if (read_addr !== 5'd4) begin
      bad++;
      $display("FAIL basic_read_addr: got %h want 04", read_addr);
    end
    collect(14, -1, 0, 1'b0);
    total++;
    if (got_d.size() !== 3) begin
      bad++;
      $display("FAIL basic_count: got %0d want 3", got_d.size());
    end
    for (int i = 0; i < 3; i++) begin
      g = (i < got_d.size()) ? got_d[i] : 'x;
      gl = (i < got_l.size()) ? got_l[i] : 1'bx;
      total++;
      if (g !== 16'h1004 + 16'(i)) begin
        bad++;
        $display("FAIL basic_data%0d: got %h want %h", i, g, 16'h1004 + 16'(i));
      end
      total++;
      if (gl !== (i == 2)) begin
        bad++;
        $display("FAIL basic_last%0d: got %b want %b", i, gl, (i == 2));
      end
    end
    total++;
    if (rise_cyc.size() !== 3) begin
      bad++;
      $display("FAIL basic_rises: got %0d want 3", rise_cyc.size());
    end else begin
      total++;
      if (rise_cyc[0] - start_cyc !== 2) begin
        bad++;
        $display("FAIL basic_latency: got %0d want 2", rise_cyc[0] - start_cyc);
      end
      total++;
      if (rise_cyc[1] - rise_cyc[0] !== 3 || rise_cyc[2] - rise_cyc[1] !== 3) begin
        bad++;
        $display("FAIL basic_spacing: got %0d,%0d want 3,3",
                 rise_cyc[1] - rise_cyc[0], rise_cyc[2] - rise_cyc[1]);
      end
    end
    total++;
    if (done_cnt !== 1) begin
      bad++;
      $display("FAIL basic_done_count: got %0d want 1", done_cnt);
    end
    total++;
    if (acc_cyc.size() == 0 || done_cyc !== acc_cyc[acc_cyc.size()-1]) begin
      bad++;
      $display("FAIL basic_done_time: got %0d want last accept edge", done_cyc);
    end
    total++;
    if (busy_at_done !== 0) begin
      bad++;
      $display("FAIL basic_busy_at_done: got %0d want 0", busy_at_done);
    end
  endtask

  task automatic test_wrap;
    logic [DW-1:0] g;
    logic gl;
    logic [DW-1:0] e;
    start_block(5'd30, 5'd0);
    collect(100, -1, 0, 1'b0);
    total++;
    if (got_d.size() !== 32) begin
      bad++;
      $display("FAIL wrap_count: got %0d want 32", got_d.size());
    end
    for (int i = 0; i < 32; i++) begin
      e = 16'h1000 + 16'((30 + i) % 32);
      g = (i < got_d.size()) ? got_d[i] : 'x;
      gl = (i < got_l.size()) ? got_l[i] : 1'bx;
      total++;
      if (g !== e || gl !== (i == 31)) begin
        bad++;
        $display("FAIL wrap_word%0d: got %h/%b want %h/%b", i, g, gl, e, (i == 31));
      end
    end
    total++;
    if (done_cnt !== 1 || acc_cyc.size() == 0
        || done_cyc !== acc_cyc[acc_cyc.size()-1]) begin
      bad++;
      $display("FAIL wrap_done: got cnt=%0d at %0d want 1 at last accept",
               done_cnt, done_cyc);
    end
  endtask

  task automatic test_backpressure;
    logic [DW-1:0] g;
    logic gl;
    start_block(5'd8, 5'd4);
    collect(30, 1, 10, 1'b0);
    total++;
    if (stalls !== 10) begin
      bad++;
      $display("FAIL bp_stalls: got %0d want 10", stalls);
    end
    total++;
    if (unstable !== 0) begin
      bad++;
      $display("FAIL bp_stable: got %0d changes want 0", unstable);
    end
    for (int i = 0; i < 4; i++) begin
      g = (i < got_d.size()) ? got_d[i] : 'x;
      gl = (i < got_l.size()) ? got_l[i] : 1'bx;
      total++;
      if (g !== 16'h1008 + 16'(i) || gl !== (i == 3)) begin
        bad++;
        $display("FAIL bp_word%0d: got %h/%b want %h/%b",
                 i, g, gl, 16'h1008 + 16'(i), (i == 3));
      end
    end
    total++;
    if (got_d.size() !== 4 || done_cnt !== 1) begin
      bad++;
      $display("FAIL bp_complete: got %0d words %0d done want 4 1",
               got_d.size(), done_cnt);
    end
  endtask

  task automatic test_abort;
    int acc;
    bit found;
    int dn;
    acc = 0;
    found = 1'b0;
    start_block(5'd10, 5'd5);
    tx_ready = 1'b1;
    for (int i = 0; i < 30 && !found; i++) begin
      if (tx_valid && acc == 1) begin
        found = 1'b1;
        tx_ready = 1'b0;
      end else begin
        if (tx_valid) acc++;
        tick();
      end
    end
    total++;
    if (!found || tx_data !== 16'h100B) begin
      bad++;
      $display("FAIL abort_word2: got %h found=%0d want 100b", tx_data, found);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    total++;
    if (tx_valid !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL abort_clear: got valid=%b busy=%b want 0 0", tx_valid, busy);
    end
    total++;
    if (done !== 1'b0 || tx_last !== 1'b0) begin
      bad++;
      $display("FAIL abort_flags: got done=%b last=%b want 0 0", done, tx_last);
    end
    tx_ready = 1'b1;
    dn = 0;
    for (int i = 0; i < 6; i++) begin
      if (done || tx_valid || busy) dn++;
      tick();
    end
    total++;
    if (dn !== 0) begin
      bad++;
      $display("FAIL abort_quiet: got %0d active cycles want 0", dn);
    end
    start_block(5'd0, 5'd1);
    collect(8, -1, 0, 1'b0);
    total++;
    if (got_d.size() !== 1 || got_d[0] !== 16'h1000 || got_l[0] !== 1'b1
        || done_cnt !== 1) begin
      bad++;
      $display("FAIL abort_restart: got n=%0d done=%0d want one 1000 last",
               got_d.size(), done_cnt);
    end
  endtask

  task automatic test_start_busy;
    logic [DW-1:0] g;
    start_block(5'd2, 5'd3);
    collect(14, -1, 0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      g = (i < got_d.size()) ? got_d[i] : 'x;
      total++;
      if (g !== 16'h1002 + 16'(i)) begin
        bad++;
        $display("FAIL sb_word%0d: got %h want %h", i, g, 16'h1002 + 16'(i));
      end
    end
    total++;
    if (got_d.size() !== 3 || done_cnt !== 1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL sb_unaffected: got n=%0d done=%0d busy=%b want 3 1 0",
               got_d.size(), done_cnt, busy);
    end
    start = 1'b1;
    abort = 1'b1;
    base_addr = 5'd3;
    word_count = 5'd2;
    tick();
    start = 1'b0;
    abort = 1'b0;
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL sb_abort_prio: got busy=%b want 0", busy);
    end
    tick();
    tick();
    total++;
    if (busy !== 1'b0 || tx_valid !== 1'b0) begin
      bad++;
      $display("FAIL sb_abort_idle: got busy=%b valid=%b want 0 0", busy, tx_valid);
    end
  endtask

  task automatic test_async_reset;
    bit found;
    found = 1'b0;
    start_block(5'd5, 5'd4);
    tx_ready = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (tx_valid) found = 1'b1;
      else tick();
    end
    total++;
    if (!found || tx_data !== 16'h1005) begin
      bad++;
      $display("FAIL ar_pre: got %h found=%0d want 1005", tx_data, found);
    end
    #2;
    reset_n = 1'b0;
    #1;
    total++;
    if (tx_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL ar_ctrl: got v=%b b=%b d=%b want 0 0 0", tx_valid, busy, done);
    end
    total++;
    if (tx_data !== 16'h0 || read_addr !== 5'd0 || tx_last !== 1'b0) begin
      bad++;
      $display("FAIL ar_data: got %h %h %b want 0000 00 0", tx_data, read_addr, tx_last);
    end
    tick();
    tick();
    reset_n = 1'b1;
    tx_ready = 1'b1;
    tick();
    total++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL ar_nodone: got done=%b busy=%b want 0 0", done, busy);
    end
    start_block(5'd6, 5'd2);
    collect(12, -1, 0, 1'b0);
    total++;
    if (got_d.size() !== 2 || got_d[0] !== 16'h1006 || got_d[1] !== 16'h1007
        || got_l[0] !== 1'b0 || got_l[1] !== 1'b1 || done_cnt !== 1) begin
      bad++;
      $display("FAIL ar_after: got n=%0d done=%0d want 1006,1007 last on 2nd",
               got_d.size(), done_cnt);
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) ram[i] = 16'h1000 + 16'(i);
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_abort();
    test_start_busy();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
